// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared divide-unit state encoding and funct3 selector codes
package riscv_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam logic [2:0] DIVSEL_DIV  = 3'b100;
  localparam logic [2:0] DIVSEL_DIVU = 3'b101;
  localparam logic [2:0] DIVSEL_REM  = 3'b110;
  localparam logic [2:0] DIVSEL_REMU = 3'b111;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-subtract step on unsigned magnitudes
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] dvs_in,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  // The shifted remainder can reach 2*divisor-1, so the compare needs one extra bit.
  always_comb begin
    trial = {rem_in, quo_in[XLEN-1]};
    diff  = trial - {1'b0, dvs_in};
    if (!diff[XLEN]) begin
      rem_out = diff[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end else begin
      rem_out = trial[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative RV32M DIV/DIVU/REM/REMU unit with hold and special-case bypass
module div_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic            hold,
  input  logic            start,
  input  logic [2:0]      divsel,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            ready,
  output logic            busy,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             is_rem_q, is_rem_d;

  logic             op_signed;
  logic             a_neg, b_neg;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic             div_zero, overflow;
  logic [XLEN-1:0]  step_rem, step_quo;
  logic [XLEN-1:0]  fix_rem, fix_quo;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .dvs_in  (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  always_comb begin
    op_signed = ~divsel[0];
    a_neg     = op_signed & dividend[XLEN-1];
    b_neg     = op_signed & divisor[XLEN-1];
    a_mag     = a_neg ? -dividend : dividend;
    b_mag     = b_neg ? -divisor : divisor;
    div_zero  = (divisor == '0);
    overflow  = op_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
    fix_quo   = neg_quo_q ? -step_quo : step_quo;
    fix_rem   = neg_rem_q ? -step_rem : step_rem;

    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;

    case (state_q)
      DIV_IDLE: begin
        if (start && divsel[2] && !hold) begin
          if (div_zero || overflow) begin
            // Both special cases finish here; overflow quotient equals the dividend.
            if (div_zero) result_d = divsel[1] ? dividend : '1;
            else          result_d = divsel[1] ? '0 : dividend;
            state_d = DIV_DONE;
          end else begin
            rem_d     = '0;
            quo_d     = a_mag;
            dvs_d     = b_mag;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            is_rem_d  = divsel[1];
            cnt_d     = CNT_W'(XLEN);
            state_d   = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        if (!hold) begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_d = is_rem_q ? fix_rem : fix_quo;
            state_d  = DIV_DONE;
          end
        end
      end
      DIV_DONE: begin
        if (!hold) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
    end
  end

  assign ready  = (state_q == DIV_DONE);
  assign busy   = (state_q == DIV_BUSY);
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed scoreboard bench for div_unit
module tb_div_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        Rst;
  logic        hold;
  logic        start;
  logic [2:0]  divsel;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        ready;
  logic        busy;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic ready_prev = 1'b0;

  div_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .Rst      (Rst),
    .hold     (hold),
    .start    (start),
    .divsel   (divsel),
    .dividend (dividend),
    .divisor  (divisor),
    .ready    (ready),
    .busy     (busy),
    .result   (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising edge of ready consumes one scoreboard entry.
  always @(negedge clk) begin
    if (ready && !ready_prev) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready: result %h at edge %0d with empty scoreboard", result, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
      end
    end
    ready_prev = ready;
  end

  // Issue one op; lat is edges from acceptance to ready (0 for special cases).
  task automatic do_op(input string name, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input int hold_after);
    int  acc;
    bit  seen;
    @(negedge clk);
    divsel   = sel;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    acc      = cyc + 1;
    sb_q.push_back('{exp, acc + lat, name});
    seen = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) begin
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0000;
      end
      if (hold_after != 0 && k == hold_after)     hold = 1'b1;
      if (hold_after != 0 && k == hold_after + 5) hold = 1'b0;
      if (ready) begin
        seen = 1;
        break;
      end
    end
    start = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: ready never seen, expected %h", name, exp);
    end
  endtask

  initial begin
    int          x;
    bit          seen;
    Rst      = 1'b1;
    hold     = 1'b0;
    start    = 1'b0;
    divsel   = 3'b000;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'b0, ready}, 32'd0);
    check("reset_busy",  {31'b0, busy},  32'd0);
    check("reset_result", result, 32'd0);
    Rst = 1'b0;

    // divsel[2]=0 must be ignored.
    divsel = 3'b001; dividend = 32'd10; divisor = 32'd2; start = 1'b1;
    repeat (4) @(negedge clk);
    check("ignored_busy",  {31'b0, busy},  32'd0);
    check("ignored_ready", {31'b0, ready}, 32'd0);
    start = 1'b0;

    do_op("divu_100_7", DIVSEL_DIVU, 32'd100, 32'd7, 32'd14, 32, 0);
    do_op("remu_100_7", DIVSEL_REMU, 32'd100, 32'd7, 32'd2, 32, 0);
    do_op("div_m7_2",   DIVSEL_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32, 0);
    do_op("rem_m7_2",   DIVSEL_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32, 0);
    do_op("rem_7_m2",   DIVSEL_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 32, 0);
    do_op("div_7_m2",   DIVSEL_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32, 0);
    do_op("div_min_2",  DIVSEL_DIV,  32'h8000_0000, 32'd2, 32'hC000_0000, 32, 0);
    do_op("divu_max_1", DIVSEL_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32, 0);
    do_op("remu_max_16", DIVSEL_REMU, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 32, 0);

    do_op("divu_5_0",  DIVSEL_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0);
    do_op("rem_5_0",   DIVSEL_REM,  32'd5, 32'd0, 32'd5, 0, 0);
    do_op("div_5_0",   DIVSEL_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0);
    do_op("remu_5_0",  DIVSEL_REMU, 32'd5, 32'd0, 32'd5, 0, 0);
    do_op("div_ovf",   DIVSEL_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
    do_op("rem_ovf",   DIVSEL_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 0);

    // Five hold cycles mid-BUSY, then hold across DONE.
    do_op("divu_hold", DIVSEL_DIVU, 32'd1000, 32'd10, 32'd100, 37, 10);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("done_hold_ready", {31'b0, ready}, 32'd1);
      check("done_hold_result", result, 32'd100);
    end
    hold = 1'b0;
    @(negedge clk);

    // Abort by reset after ten BUSY cycles.
    @(negedge clk);
    divsel = DIVSEL_DIVU; dividend = 32'hFFFF_FFFF; divisor = 32'd3; start = 1'b1;
    repeat (10) @(negedge clk);
    start = 1'b0;
    check("abort_busy_before", {31'b0, busy}, 32'd1);
    Rst = 1'b1;
    @(negedge clk);
    Rst = 1'b0;
    check("abort_ready",  {31'b0, ready}, 32'd0);
    check("abort_busy",   {31'b0, busy},  32'd0);
    check("abort_result", result, 32'd0);
    do_op("divu_9_3", DIVSEL_DIVU, 32'd9, 32'd3, 32'd3, 32, 0);

    // Back-to-back with start held: second accept is two edges after first ready.
    @(negedge clk);
    divsel = DIVSEL_DIVU; dividend = 32'd20; divisor = 32'd4; start = 1'b1;
    sb_q.push_back('{32'd5, cyc + 1 + 32, "b2b_first"});
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ready) begin seen = 1; break; end
    end
    divsel = DIVSEL_REMU; dividend = 32'd20; divisor = 32'd6;
    x = cyc;
    sb_q.push_back('{32'd2, x + 34, "b2b_second"});
    @(negedge clk);
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ready) begin seen = 1; break; end
    end
    start = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL b2b_timeout: second ready never seen");
    end
    repeat (3) @(negedge clk);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
